vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator: divides the system clock into a pixel-rate strobe and walks horizontal/vertical counters over a configurable total raster. Produces registered, mutually aligned sync, display-enable, pixel-coordinate and frame/line markers. Successor to the fixed 640x480 sync generator: sync widths, porches, polarities, clock division and an enable input are all configurable. Sits between the clock source and the pixel/colour pipeline that drives the VGA DAC pins.

---
 rtl/vga_timing_gen_pkg.sv | 55 +++++
 rtl/vga_timing_gen_if.sv | 36 +++
 rtl/vga_timing_gen_axis_counter.sv | 58 +++++
 rtl/vga_timing_gen.sv | 144 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//   Shared constants for the VGA raster timing generator:
//   - sync polarity encoding
//   - mode presets (640x480@60 from 50 MHz with CLK_DIV=2,
//     800x600@72 from 50 MHz with CLK_DIV=1)
//   - clog2 helper used for elaboration-time width checks
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic {
        SYNC_NEG = 1'b0,
        SYNC_POS = 1'b1
    } sync_pol_e;

    // 640x480@60, 25 MHz pixel clock
    localparam int        VGA640_H_ACTIVE = 640;
    localparam int        VGA640_H_FP     = 16;
    localparam int        VGA640_H_SYNC   = 96;
    localparam int        VGA640_H_BP     = 48;
    localparam int        VGA640_V_ACTIVE = 480;
    localparam int        VGA640_V_FP     = 10;
    localparam int        VGA640_V_SYNC   = 2;
    localparam int        VGA640_V_BP     = 33;
    localparam sync_pol_e VGA640_HS_POL   = SYNC_NEG;
    localparam sync_pol_e VGA640_VS_POL   = SYNC_NEG;
    localparam int        VGA640_CLK_DIV  = 2;

    // 800x600@72, 50 MHz pixel clock
    localparam int        SVGA800_H_ACTIVE = 800;
    localparam int        SVGA800_H_FP     = 56;
    localparam int        SVGA800_H_SYNC   = 120;
    localparam int        SVGA800_H_BP     = 64;
    localparam int        SVGA800_V_ACTIVE = 600;
    localparam int        SVGA800_V_FP     = 37;
    localparam int        SVGA800_V_SYNC   = 6;
    localparam int        SVGA800_V_BP     = 23;
    localparam sync_pol_e SVGA800_HS_POL   = SYNC_POS;
    localparam sync_pol_e SVGA800_VS_POL   = SYNC_POS;
    localparam int        SVGA800_CLK_DIV  = 1;

    // Number of bits needed to represent values 0..value-1 (0 for value<=1).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
//   Bundle between the timing generator and the pixel/colour pipeline.
//   en          : advance enable, driven by the consumer side
//   pix_ce      : one-clk strobe on the first clk of each new pixel
//   hsync/vsync : sync outputs at the configured polarity
//   de          : display enable (inside active area)
//   x / y       : current pixel column / line
//   line_start  : high for the whole pixel at x==0
//   frame_start : high for the whole pixel at x==0, y==0
//   master = generator side, slave = consumer side.
// -----------------------------------------------------------------------------
interface vga_timing_gen_if #(
    parameter int X_W = 11,
    parameter int Y_W = 10
);
    logic           en;
    logic           pix_ce;
    logic           hsync;
    logic           vsync;
    logic           de;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           line_start;
    logic           frame_start;

    modport master (
        input  en,
        output pix_ce, hsync, vsync, de, x, y, line_start, frame_start
    );

    modport slave (
        output en,
        input  pix_ce, hsync, vsync, de, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//   One raster axis (horizontal or vertical). Walks 0..TOTAL-1 on each step
//   and decodes the position the counter moves to on this step, so the parent
//   can register the decode on the same edge as the count.
//   clk, rst_n : clock, asynchronous active-low reset
//   step       : advance by one position
//   count      : position after this step (current position when not stepping)
//   wrap       : this step moves TOTAL-1 -> 0
//   active     : count lies in the active region
//   sync       : sync level for count (POL inside the sync region, ~POL else)
// -----------------------------------------------------------------------------
module vga_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    parameter int W      = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         sync
);
    localparam int         TOTAL    = ACTIVE + FP + SYNC + BP;
    localparam logic [W:0] LAST_X   = (W+1)'(TOTAL - 1);
    localparam logic [W:0] ACT_X    = (W+1)'(ACTIVE);
    localparam logic [W:0] SYNC_B_X = (W+1)'(ACTIVE + FP);
    localparam logic [W:0] SYNC_E_X = (W+1)'(ACTIVE + FP + SYNC);

    logic [W-1:0] r_count;
    logic [W-1:0] w_next;
    logic [W:0]   w_next_x;
    logic         w_last;

    assign w_last   = ({1'b0, r_count} == LAST_X);
    assign w_next   = !step ? r_count : (w_last ? '0 : r_count + 1'b1);
    // one extra bit so region bounds equal to 2**W still compare correctly
    assign w_next_x = {1'b0, w_next};

    assign count  = w_next;
    assign wrap   = step && w_last;
    assign active = (w_next_x < ACT_X);
    assign sync   = ((w_next_x >= SYNC_B_X) && (w_next_x < SYNC_E_X)) ? POL : ~POL;

    // Parked on the last position so the first step after reset lands on 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= W'(TOTAL - 1);
        end else begin
            r_count <= w_next;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA raster timing generator. A prescaler turns the system
//   clock into a pixel tick; horizontal and vertical axis counters walk the
//   raster; all outputs are registered together on the tick edge.
//   clk   : system clock (single domain)
//   rst_n : asynchronous active-low reset (released synchronously upstream)
//   bus   : vga_timing_gen_if master (en in; pix_ce, hsync, vsync, de,
//           x, y, line_start, frame_start out)
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int X_W      = 11,
    parameter int Y_W      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_timing_gen_if.master  bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if (clog2(H_TOTAL) > X_W) begin : g_bad_x_w
        $error("vga_timing_gen: X_W too narrow for H_TOTAL-1");
    end
    if (clog2(V_TOTAL) > Y_W) begin : g_bad_y_w
        $error("vga_timing_gen: Y_W too narrow for V_TOTAL-1");
    end

    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    logic [X_W-1:0]   w_h_count;
    logic [Y_W-1:0]   w_v_count;
    logic             w_h_wrap, w_v_wrap;
    logic             w_h_active, w_v_active;
    logic             w_h_sync, w_v_sync;

    logic             r_pix_ce_p1;
    logic             r_hsync_p1;
    logic             r_vsync_p1;
    logic             r_de_p1;
    logic [X_W-1:0]   r_x_p1;
    logic [Y_W-1:0]   r_y_p1;
    logic             r_line_start_p1;
    logic             r_frame_start_p1;

    // With CLK_DIV=1 DIV_LAST is 0 and r_div never leaves 0, so tick == en.
    assign w_tick = bus.en && (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (bus.en) begin
            r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL),
        .W      (X_W)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (w_tick),
        .count  (w_h_count),
        .wrap   (w_h_wrap),
        .active (w_h_active),
        .sync   (w_h_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL),
        .W      (Y_W)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (w_h_wrap),
        .count  (w_v_count),
        .wrap   (w_v_wrap),
        .active (w_v_active),
        .sync   (w_v_sync)
    );

    // ---- stage p1: registered outputs, all updated on the tick edge ----
    // The new h is 0 exactly when h wraps; v only steps on an h wrap, so the
    // new position is (0,0) exactly when v wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_ce_p1      <= 1'b0;
            r_hsync_p1       <= ~HS_POL;
            r_vsync_p1       <= ~VS_POL;
            r_de_p1          <= 1'b0;
            r_x_p1           <= '0;
            r_y_p1           <= '0;
            r_line_start_p1  <= 1'b0;
            r_frame_start_p1 <= 1'b0;
        end else begin
            r_pix_ce_p1 <= w_tick;
            if (w_tick) begin
                r_hsync_p1       <= w_h_sync;
                r_vsync_p1       <= w_v_sync;
                r_de_p1          <= w_h_active && w_v_active;
                r_x_p1           <= w_h_count;
                r_y_p1           <= w_v_count;
                r_line_start_p1  <= w_h_wrap;
                r_frame_start_p1 <= w_v_wrap;
            end
        end
    end

    assign bus.pix_ce      = r_pix_ce_p1;
    assign bus.hsync       = r_hsync_p1;
    assign bus.vsync       = r_vsync_p1;
    assign bus.de          = r_de_p1;
    assign bus.x           = r_x_p1;
    assign bus.y           = r_y_p1;
    assign bus.line_start  = r_line_start_p1;
    assign bus.frame_start = r_frame_start_p1;
endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;
    import vga_pkg::*;

    typedef struct packed {
        logic        pix_ce;
        logic        hsync;
        logic        vsync;
        logic        de;
        logic [10:0] x;
        logic [9:0]  y;
        logic        ls;
        logic        fs;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;

    int n_cmp = 0;
    int n_bad = 0;

    // index 0: defaults, 1: 800x600@72 preset, 2: small raster 15x8, CLK_DIV=3
    int p_ha [3] = '{640, 800, 8};
    int p_hf [3] = '{16, 56, 2};
    int p_hs [3] = '{96, 120, 3};
    int p_hb [3] = '{48, 64, 2};
    int p_va [3] = '{480, 600, 4};
    int p_vf [3] = '{10, 37, 1};
    int p_vs [3] = '{2, 6, 2};
    int p_vb [3] = '{33, 23, 1};
    int p_hp [3] = '{0, 1, 1};
    int p_vp [3] = '{0, 1, 0};
    int p_cd [3] = '{2, 1, 3};

    longint enc [3];
    longint tks [3];

    vga_timing_gen_if #(.X_W(11), .Y_W(10)) if_a ();
    vga_timing_gen_if #(.X_W(11), .Y_W(10)) if_b ();
    vga_timing_gen_if #(.X_W(4),  .Y_W(3))  if_c ();

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2),  .V_BP(33),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2), .X_W(11), .Y_W(10)
    ) dut_a (.clk(clk), .rst_n(rst_a), .bus(if_a.master));

    vga_timing_gen #(
        .H_ACTIVE(SVGA800_H_ACTIVE), .H_FP(SVGA800_H_FP), .H_SYNC(SVGA800_H_SYNC), .H_BP(SVGA800_H_BP),
        .V_ACTIVE(SVGA800_V_ACTIVE), .V_FP(SVGA800_V_FP), .V_SYNC(SVGA800_V_SYNC), .V_BP(SVGA800_V_BP),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(SVGA800_CLK_DIV), .X_W(11), .Y_W(10)
    ) dut_b (.clk(clk), .rst_n(rst_b), .bus(if_b.master));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(3), .X_W(4), .Y_W(3)
    ) dut_c (.clk(clk), .rst_n(rst_c), .bus(if_c.master));

    obs_t o_a, o_b, o_c;
    assign o_a = {if_a.pix_ce, if_a.hsync, if_a.vsync, if_a.de, if_a.x, if_a.y,
                  if_a.line_start, if_a.frame_start};
    assign o_b = {if_b.pix_ce, if_b.hsync, if_b.vsync, if_b.de, if_b.x, if_b.y,
                  if_b.line_start, if_b.frame_start};
    assign o_c = {if_c.pix_ce, if_c.hsync, if_c.vsync, if_c.de, 7'd0, if_c.x, 7'd0, if_c.y,
                  if_c.line_start, if_c.frame_start};

    function automatic string fmt(obs_t o);
        return $sformatf("x=%0d y=%0d ce=%b hs=%b vs=%b de=%b ls=%b fs=%b",
                         o.x, o.y, o.pix_ce, o.hsync, o.vsync, o.de, o.ls, o.fs);
    endfunction

    function automatic obs_t get_obs(int d);
        case (d)
            0:       return o_a;
            1:       return o_b;
            default: return o_c;
        endcase
    endfunction

    // Reference: the n-th pixel tick since reset presents raster index n-1,
    // laid out row-major over H_TOTAL x V_TOTAL.
    function automatic obs_t model(int d, bit tk);
        obs_t   r;
        int     ht, vt, h, v;
        longint p;
        ht = p_ha[d] + p_hf[d] + p_hs[d] + p_hb[d];
        vt = p_va[d] + p_vf[d] + p_vs[d] + p_vb[d];
        r = '0;
        r.pix_ce = tk;
        if (tks[d] == 0) begin
            r.hsync = (p_hp[d] == 0);
            r.vsync = (p_vp[d] == 0);
        end else begin
            p = tks[d] - 1;
            h = int'(p % ht);
            v = int'((p / ht) % vt);
            r.x  = 11'(h);
            r.y  = 10'(v);
            r.de = (h < p_ha[d]) && (v < p_va[d]);
            r.hsync = (h >= p_ha[d] + p_hf[d] && h < p_ha[d] + p_hf[d] + p_hs[d]) ?
                      (p_hp[d] != 0) : (p_hp[d] == 0);
            r.vsync = (v >= p_va[d] + p_vf[d] && v < p_va[d] + p_vf[d] + p_vs[d]) ?
                      (p_vp[d] != 0) : (p_vp[d] == 0);
            r.ls = (h == 0);
            r.fs = (h == 0) && (v == 0);
        end
        return r;
    endfunction

    task automatic set_en(input int d, input bit e);
        case (d)
            0:       if_a.en = e;
            1:       if_b.en = e;
            default: if_c.en = e;
        endcase
    endtask

    task automatic set_rst(input int d, input logic v);
        case (d)
            0:       rst_a = v;
            1:       rst_b = v;
            default: rst_c = v;
        endcase
    endtask

    // One clk: drive en, take the edge, update the reference, sample at negedge.
    task automatic cyc(input int d, input bit e, output obs_t ob, output obs_t ex);
        bit tk;
        set_en(d, e);
        @(posedge clk);
        tk = 1'b0;
        if (e) begin
            enc[d]++;
            if (enc[d] % p_cd[d] == 0) begin
                tk = 1'b1;
                tks[d]++;
            end
        end
        @(negedge clk);
        ob = get_obs(d);
        ex = model(d, tk);
    endtask

    task automatic do_reset(input int d);
        set_rst(d, 1'b0);
        enc[d] = 0;
        tks[d] = 0;
        repeat (2) @(negedge clk);
        set_rst(d, 1'b1);
    endtask

    task automatic test_reset();
        obs_t ex;
        for (int d = 0; d < 3; d++) begin
            tks[d] = 0;
            ex = model(d, 1'b0);
            n_cmp++;
            if (get_obs(d) !== ex) begin
                n_bad++;
                $display("FAIL reset_values dut%0d got %s exp %s", d, fmt(get_obs(d)), fmt(ex));
            end
        end
    endtask

    task automatic test_default_line();
        obs_t ob, ex;
        int hs_cnt = 0, hs_first = -1, hs_last = -1, first_tick = -1;
        int ls_clk [$];
        do_reset(0);
        for (int i = 0; i < 3210; i++) begin
            cyc(0, 1'b1, ob, ex);
            n_cmp++;
            if (ob !== ex) begin
                n_bad++;
                $display("FAIL line_model clk=%0d got %s exp %s", i, fmt(ob), fmt(ex));
            end
            if (ob.pix_ce) begin
                if (first_tick < 0) begin
                    first_tick = i;
                    n_cmp++;
                    if (ob.x !== 0 || ob.y !== 0 || ob.de !== 1'b1 || ob.fs !== 1'b1 || ob.ls !== 1'b1) begin
                        n_bad++;
                        $display("FAIL first_pixel got %s exp x=0 y=0 de=1 ls=1 fs=1", fmt(ob));
                    end
                end
                if (ob.y == 0 && ob.hsync == 1'b0) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(ob.x);
                    hs_last = int'(ob.x);
                end
                if (ob.ls) ls_clk.push_back(i);
            end
        end
        n_cmp++;
        if (first_tick != 1) begin
            n_bad++;
            $display("FAIL first_tick_clk got %0d exp 1", first_tick);
        end
        n_cmp++;
        if (hs_cnt != 96 || hs_first != 656 || hs_last != 751) begin
            n_bad++;
            $display("FAIL hsync_window got n=%0d %0d..%0d exp n=96 656..751", hs_cnt, hs_first, hs_last);
        end
        n_cmp++;
        if (ls_clk.size() < 2) begin
            n_bad++;
            $display("FAIL line_period got %0d line starts exp >=2", ls_clk.size());
        end else if (ls_clk[1] - ls_clk[0] != 1600) begin
            n_bad++;
            $display("FAIL line_period got %0d clks exp 1600", ls_clk[1] - ls_clk[0]);
        end
    endtask

    task automatic test_preset();
        obs_t ob, ex;
        int ce_low = 0, hs_cnt = 0, hs_first = -1, hs_last = -1, de_cnt = 0;
        do_reset(1);
        for (int i = 0; i < 2085; i++) begin
            cyc(1, 1'b1, ob, ex);
            n_cmp++;
            if (ob !== ex) begin
                n_bad++;
                $display("FAIL preset_model clk=%0d got %s exp %s", i, fmt(ob), fmt(ex));
            end
            if (!ob.pix_ce) ce_low++;
            if (ob.y == 0 && ob.hsync == 1'b1) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(ob.x);
                hs_last = int'(ob.x);
            end
            if (ob.y == 0 && ob.de) de_cnt++;
        end
        n_cmp++;
        if (ce_low != 0) begin
            n_bad++;
            $display("FAIL preset_pix_ce got %0d low clks exp 0", ce_low);
        end
        n_cmp++;
        if (hs_cnt != 120 || hs_first != 856 || hs_last != 975) begin
            n_bad++;
            $display("FAIL preset_hsync got n=%0d %0d..%0d exp n=120 856..975", hs_cnt, hs_first, hs_last);
        end
        n_cmp++;
        if (de_cnt != 800) begin
            n_bad++;
            $display("FAIL preset_de_line got %0d exp 800", de_cnt);
        end
    endtask

    task automatic test_small_frame();
        obs_t ob, ex;
        int frame = -1, de_cnt = 0, vs_cnt = 0, vs_min = 99, vs_max = -1, hs_cnt = 0;
        int fs_clk [$];
        do_reset(2);
        for (int i = 0; i < 725; i++) begin
            cyc(2, 1'b1, ob, ex);
            n_cmp++;
            if (ob !== ex) begin
                n_bad++;
                $display("FAIL frame_model clk=%0d got %s exp %s", i, fmt(ob), fmt(ex));
            end
            if (ob.pix_ce) begin
                if (ob.fs) begin
                    frame++;
                    fs_clk.push_back(i);
                end
                if (frame == 0) begin
                    if (ob.de) de_cnt++;
                    if (ob.hsync) hs_cnt++;
                    if (!ob.vsync) begin
                        vs_cnt++;
                        if (int'(ob.y) < vs_min) vs_min = int'(ob.y);
                        if (int'(ob.y) > vs_max) vs_max = int'(ob.y);
                    end
                end
            end
        end
        n_cmp++;
        if (de_cnt != 32) begin
            n_bad++;
            $display("FAIL frame_de_count got %0d exp 32", de_cnt);
        end
        n_cmp++;
        if (vs_cnt != 30 || vs_min != 5 || vs_max != 6) begin
            n_bad++;
            $display("FAIL frame_vsync got n=%0d rows %0d..%0d exp n=30 rows 5..6", vs_cnt, vs_min, vs_max);
        end
        n_cmp++;
        if (hs_cnt != 24) begin
            n_bad++;
            $display("FAIL frame_hsync_count got %0d exp 24", hs_cnt);
        end
        n_cmp++;
        if (fs_clk.size() != 3) begin
            n_bad++;
            $display("FAIL frame_start_count got %0d exp 3", fs_clk.size());
        end else if (fs_clk[1] - fs_clk[0] != 360 || fs_clk[2] - fs_clk[1] != 360) begin
            n_bad++;
            $display("FAIL frame_period got %0d/%0d exp 360", fs_clk[1] - fs_clk[0], fs_clk[2] - fs_clk[1]);
        end
    endtask

    task automatic test_back_to_back();
        obs_t ob, ex;
        bit found = 1'b0;
        do_reset(2);
        for (int i = 0; i < 400 && !found; i++) begin
            cyc(2, 1'b1, ob, ex);
            n_cmp++;
            if (ob !== ex) begin
                n_bad++;
                $display("FAIL wrap_model clk=%0d got %s exp %s", i, fmt(ob), fmt(ex));
            end
            if (ob.pix_ce && ob.x == 14 && ob.y == 7) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL wrap_reach_last got none exp pixel (14,7) within 400 clks");
        end else if (ob.vsync !== 1'b1 || ob.de !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_last_pixel got %s exp vs=1 de=0", fmt(ob));
        end
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            cyc(2, 1'b1, ob, ex);
            if (ob.pix_ce) found = 1'b1;
        end
        n_cmp++;
        if (!found || ob.x !== 0 || ob.y !== 0 || ob.ls !== 1'b1 || ob.fs !== 1'b1 ||
            ob.de !== 1'b1 || ob.vsync !== 1'b1 || ob.hsync !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_first_pixel got %s (seen=%0b) exp x=0 y=0 hs=0 vs=1 de=1 ls=1 fs=1", fmt(ob), found);
        end
    endtask

    task automatic test_en_freeze();
        obs_t ob, ex, held;
        bit found = 1'b0;
        int wait_n;
        do_reset(0);
        for (int i = 0; i < 500 && !found; i++) begin
            cyc(0, 1'b1, ob, ex);
            n_cmp++;
            if (ob !== ex) begin
                n_bad++;
                $display("FAIL freeze_model clk=%0d got %s exp %s", i, fmt(ob), fmt(ex));
            end
            if (ob.pix_ce && ob.x == 100) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL freeze_reach got none exp x=100 within 500 clks");
        end
        // drop en right at a pixel boundary, then again mid-pixel
        for (int pass = 0; pass < 2; pass++) begin
            held = ob;
            held.pix_ce = 1'b0;
            for (int i = 0; i < 7; i++) begin
                cyc(0, 1'b0, ob, ex);
                n_cmp++;
                if (ob !== held || ob !== ex) begin
                    n_bad++;
                    $display("FAIL freeze_hold pass=%0d clk=%0d got %s exp %s", pass, i, fmt(ob), fmt(held));
                end
            end
            wait_n = 0;
            found = 1'b0;
            for (int i = 0; i < 6 && !found; i++) begin
                cyc(0, 1'b1, ob, ex);
                wait_n++;
                n_cmp++;
                if (ob !== ex) begin
                    n_bad++;
                    $display("FAIL resume_model pass=%0d got %s exp %s", pass, fmt(ob), fmt(ex));
                end
                if (ob.pix_ce) found = 1'b1;
            end
            n_cmp++;
            if (!found || wait_n != 2 - pass || int'(ob.x) != 101 + pass) begin
                n_bad++;
                $display("FAIL resume_next pass=%0d got x=%0d after %0d clks exp x=%0d after %0d clks",
                         pass, ob.x, wait_n, 101 + pass, 2 - pass);
            end
            if (pass == 0) cyc(0, 1'b1, ob, ex);
        end
    endtask

    task automatic test_random_en();
        obs_t ob, ex;
        int ds [2] = '{2, 0};
        int ns [2] = '{1200, 400};
        for (int k = 0; k < 2; k++) begin
            do_reset(ds[k]);
            for (int i = 0; i < ns[k]; i++) begin
                cyc(ds[k], ($urandom_range(3) != 0), ob, ex);
                n_cmp++;
                if (ob !== ex) begin
                    n_bad++;
                    $display("FAIL random_en dut%0d clk=%0d got %s exp %s", ds[k], i, fmt(ob), fmt(ex));
                end
            end
            set_en(ds[k], 1'b1);
        end
    endtask

    task automatic test_async_reset();
        obs_t ob, ex, rv;
        bit found;
        int ds [2] = '{2, 0};
        int tx [2] = '{5, 300};
        int ty [2] = '{3, 0};
        int wait_n;
        for (int k = 0; k < 2; k++) begin
            do_reset(ds[k]);
            found = 1'b0;
            for (int i = 0; i < 800 && !found; i++) begin
                cyc(ds[k], 1'b1, ob, ex);
                if (ob.pix_ce && int'(ob.x) == tx[k] && int'(ob.y) == ty[k]) found = 1'b1;
            end
            n_cmp++;
            if (!found) begin
                n_bad++;
                $display("FAIL async_reach dut%0d got none exp (%0d,%0d)", ds[k], tx[k], ty[k]);
            end
            // assert mid-cycle, well away from any clk edge
            #2;
            set_rst(ds[k], 1'b0);
            enc[ds[k]] = 0;
            tks[ds[k]] = 0;
            #1;
            rv = '0;
            rv.hsync = (ds[k] == 2) ? 1'b0 : 1'b1;
            rv.vsync = 1'b1;
            ob = get_obs(ds[k]);
            n_cmp++;
            if (ob !== rv) begin
                n_bad++;
                $display("FAIL async_reset_values dut%0d got %s exp %s", ds[k], fmt(ob), fmt(rv));
            end
            @(negedge clk);
            @(negedge clk);
            set_rst(ds[k], 1'b1);
            wait_n = 0;
            found = 1'b0;
            for (int i = 0; i < 8 && !found; i++) begin
                cyc(ds[k], 1'b1, ob, ex);
                wait_n++;
                n_cmp++;
                if (ob !== ex) begin
                    n_bad++;
                    $display("FAIL async_restart_model dut%0d got %s exp %s", ds[k], fmt(ob), fmt(ex));
                end
                if (ob.pix_ce) found = 1'b1;
            end
            n_cmp++;
            if (!found || wait_n != p_cd[ds[k]] || ob.x !== 0 || ob.y !== 0 || ob.fs !== 1'b1 || ob.de !== 1'b1) begin
                n_bad++;
                $display("FAIL async_first_tick dut%0d got %s after %0d clks exp x=0 y=0 de=1 fs=1 after %0d",
                         ds[k], fmt(ob), wait_n, p_cd[ds[k]]);
            end
        end
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        if_a.en = 1'b1;
        if_b.en = 1'b1;
        if_c.en = 1'b1;
        for (int d = 0; d < 3; d++) begin
            enc[d] = 0;
            tks[d] = 0;
        end
        repeat (2) @(negedge clk);
        test_reset();
        test_default_line();
        test_preset();
        test_small_frame();
        test_back_to_back();
        test_en_freeze();
        test_random_en();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end
endmodule
